// File: rtl/control_pkg.sv
// Shared definitions for the multicycle RISC-V control path:
// state codes, opcodes, ALU operation classes and the strobe bundle.
package control_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'b0000,
    DECODE    = 4'b0001,
    EXEC_R    = 4'b0010,
    EXEC_I    = 4'b0011,
    MEM_ADDR  = 4'b0100,
    MEM_READ  = 4'b0101,
    WB_ALU    = 4'b0110,
    WB_MEM    = 4'b0111,
    MEM_WRITE = 4'b1000,
    BRANCH    = 4'b1001,
    HALT      = 4'b1111
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       pcbranch;
    logic       alusrc;
    logic [1:0] aluop;
    logic       memread;
    logic       memwrite;
    logic       regiwrite;
    logic       memtoreg;
    logic       halted;
  } strobes_t;

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decoder: maps the current state (plus funct3/zero
// for the branch decision) to the full set of datapath strobes.
module control_decode
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] funct3,
  input  logic       zero,
  output strobes_t   strobes
);

  always_comb begin
    strobes = '0;
    case (state)
      FETCH: begin
        strobes.irwrite = 1'b1;
        strobes.pcwrite = 1'b1;
      end
      EXEC_R: begin
        strobes.alusrc = 1'b0;
        strobes.aluop  = ALUOP_RTYPE;
      end
      EXEC_I: begin
        strobes.alusrc = 1'b1;
        strobes.aluop  = ALUOP_ITYPE;
      end
      MEM_ADDR: begin
        strobes.alusrc = 1'b1;
        strobes.aluop  = ALUOP_ADD;
      end
      MEM_READ:  strobes.memread = 1'b1;
      WB_ALU: begin
        strobes.regiwrite = 1'b1;
        strobes.memtoreg  = 1'b0;
      end
      WB_MEM: begin
        strobes.regiwrite = 1'b1;
        strobes.memtoreg  = 1'b1;
      end
      MEM_WRITE: strobes.memwrite = 1'b1;
      BRANCH: begin
        strobes.alusrc = 1'b0;
        strobes.aluop  = ALUOP_SUB;
        // Only beq/bne are supported; other funct3 values never branch
        strobes.pcbranch = ((funct3 == F3_BEQ) && zero) ||
                           ((funct3 == F3_BNE) && !zero);
      end
      HALT:      strobes.halted = 1'b1;
      default:   strobes = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: state register, next-state logic and the
// retired-instruction counter; strobes come from control_decode.
module multicycle_control
  import control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  output logic [3:0]       estado,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcbranch,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             memread,
  output logic             memwrite,
  output logic             regiwrite,
  output logic             memtoreg,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     nextState;
  strobes_t   decoded;
  strobes_t   strobes;
  logic       retiring;
  logic [CNT_W-1:0] retiredCount;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = HALT;
    case (state)
      FETCH:    nextState = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:               nextState = EXEC_R;
          OP_I:               nextState = EXEC_I;
          OP_LOAD, OP_STORE:  nextState = MEM_ADDR;
          OP_BRANCH:          nextState = BRANCH;
          default:            nextState = HALT;
        endcase
      end
      EXEC_R:    nextState = WB_ALU;
      EXEC_I:    nextState = WB_ALU;
      MEM_ADDR:  nextState = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:  nextState = WB_MEM;
      WB_ALU:    nextState = FETCH;
      WB_MEM:    nextState = FETCH;
      MEM_WRITE: nextState = FETCH;
      BRANCH:    nextState = FETCH;
      HALT:      nextState = HALT;
      default:   nextState = HALT;
    endcase
  end

  // An instruction retires on the edge leaving its final state
  assign retiring = (state == WB_ALU) || (state == WB_MEM) ||
                    (state == MEM_WRITE) || (state == BRANCH);

  always_ff @(posedge clk) begin
    if (reset)         retiredCount <= '0;
    else if (retiring) retiredCount <= retiredCount + 1'b1;
  end

  control_decode u_decode (
    .state   (state),
    .funct3  (funct3),
    .zero    (zero),
    .strobes (decoded)
  );

  // Reset silences every strobe, even while the register already reads FETCH
  always_comb begin
    strobes = decoded;
    if (reset) strobes = '0;
  end

  assign estado    = state;
  assign irwrite   = strobes.irwrite;
  assign pcwrite   = strobes.pcwrite;
  assign pcbranch  = strobes.pcbranch;
  assign alusrc    = strobes.alusrc;
  assign aluop     = strobes.aluop;
  assign memread   = strobes.memread;
  assign memwrite  = strobes.memwrite;
  assign regiwrite = strobes.regiwrite;
  assign memtoreg  = strobes.memtoreg;
  assign halted    = strobes.halted;
  assign retired   = retiredCount;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against an
// instruction-level reference model (state sequence and strobe table).
module tb_multicycle_control;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                zero;
  logic [3:0]          estado;
  logic                irwrite, pcwrite, pcbranch, alusrc;
  logic [1:0]          aluop;
  logic                memread, memwrite, regiwrite, memtoreg, halted;
  logic [TB_CNT_W-1:0] retired;

  int checks   = 0;
  int failures = 0;
  int expRetired = 0;

  multicycle_control #(.CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .zero      (zero),
    .estado    (estado),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .pcbranch  (pcbranch),
    .alusrc    (alusrc),
    .aluop     (aluop),
    .memread   (memread),
    .memwrite  (memwrite),
    .regiwrite (regiwrite),
    .memtoreg  (memtoreg),
    .halted    (halted),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  // Strobe vector {irwrite,pcwrite,pcbranch,alusrc,aluop,memread,memwrite,regiwrite,memtoreg,halted}
  function automatic logic [10:0] expStrobes(input int code, input logic [2:0] f3,
                                             input logic z);
    logic [10:0] s;
    s = '0;
    case (code)
      0:  s = 11'b11_0_0_00_0_0_0_0_0;
      2:  s = 11'b00_0_0_10_0_0_0_0_0;
      3:  s = 11'b00_0_1_11_0_0_0_0_0;
      4:  s = 11'b00_0_1_00_0_0_0_0_0;
      5:  s = 11'b00_0_0_00_1_0_0_0_0;
      6:  s = 11'b00_0_0_00_0_0_1_0_0;
      7:  s = 11'b00_0_0_00_0_0_1_1_0;
      8:  s = 11'b00_0_0_00_0_1_0_0_0;
      9:  s = {2'b00, ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z), 1'b0, 2'b01, 5'b0};
      15: s = 11'b00_0_0_00_0_0_0_0_1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [10:0] dutStrobes();
    return {irwrite, pcwrite, pcbranch, alusrc, aluop, memread, memwrite,
            regiwrite, memtoreg, halted};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input int code, input string tag);
    checkOutput({tag, ".estado"}, 32'(estado), 32'(code));
    checkOutput({tag, ".strobes"}, 32'(dutStrobes()), 32'(expStrobes(code, funct3, zero)));
    checkOutput({tag, ".retired"}, 32'(retired), 32'(expRetired));
  endtask

  task automatic resetDut(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      stepCycle();
      expRetired = 0;
      checkOutput("reset.estado", 32'(estado), 32'd0);
      checkOutput("reset.retired", 32'(retired), 32'd0);
      checkOutput("reset.strobes", 32'(dutStrobes()), 32'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("release.fetch", 32'(dutStrobes()), 32'(expStrobes(0, funct3, zero)));
  endtask

  // Run one instruction from FETCH; zsel < 0 means random zero flag
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input int zsel);
    int seq[$];
    opcode = op;
    funct3 = f3;
    case (op)
      7'b0110011: seq = '{0, 1, 2, 6};
      7'b0010011: seq = '{0, 1, 3, 6};
      7'b0000011: seq = '{0, 1, 4, 5, 7};
      7'b0100011: seq = '{0, 1, 4, 8};
      7'b1100011: seq = '{0, 1, 9};
      default:    seq = '{0, 1};
    endcase
    foreach (seq[i]) begin
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      checkCycle(seq[i], $sformatf("op%b.c%0d", op, i));
      stepCycle();
    end
    if (seq.size() == 2) begin
      for (int i = 0; i < 20; i++) begin
        zero = 1'($urandom_range(0, 1));
        #1;
        checkCycle(15, "halt");
        stepCycle();
      end
      resetDut(1);
    end else begin
      expRetired = (expRetired + 1) % (1 << TB_CNT_W);
    end
  endtask

  task automatic resetDuringLoad();
    int seq[$];
    seq = '{0, 1, 4, 5};
    opcode = 7'b0000011;
    funct3 = 3'd2;
    foreach (seq[i]) begin
      #1;
      checkCycle(seq[i], $sformatf("lwrst.c%0d", i));
      if (i < 3) stepCycle();
    end
    reset = 1'b1;
    stepCycle();
    expRetired = 0;
    checkOutput("lwrst.estado", 32'(estado), 32'd0);
    checkOutput("lwrst.regiwrite", 32'(regiwrite), 32'd0);
    checkOutput("lwrst.retired", 32'(retired), 32'd0);
    reset = 1'b0;
    #1;
    checkCycle(0, "lwrst.fetch");
  endtask

  function automatic logic [6:0] pickOpcode();
    int r;
    logic [6:0] op;
    r = $urandom_range(0, 19);
    if (r < 4)       op = 7'b0110011;
    else if (r < 8)  op = 7'b0010011;
    else if (r < 11) op = 7'b0000011;
    else if (r < 14) op = 7'b0100011;
    else if (r < 19) op = 7'b1100011;
    else begin
      op = 7'($urandom_range(0, 127));
      if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
          op == 7'b0100011 || op == 7'b1100011)
        op = 7'b0000000;
    end
    return op;
  endfunction

  initial begin
    reset  = 1'b1;
    opcode = 7'b0;
    funct3 = 3'b0;
    zero   = 1'b0;
    #1;
    resetDut(2);

    applyStimulus(7'b0110011, 3'd0, -1);
    applyStimulus(7'b0000011, 3'd2, -1);
    applyStimulus(7'b1100011, 3'd0, 1);
    applyStimulus(7'b1100011, 3'd0, 0);
    applyStimulus(7'b1100011, 3'd1, 0);
    applyStimulus(7'b1100011, 3'd1, 1);
    applyStimulus(7'b0100011, 3'd2, -1);
    applyStimulus(7'b0010011, 3'd0, -1);
    applyStimulus(7'b0000000, 3'd0, -1);
    resetDuringLoad();

    for (int n = 0; n < 300; n++)
      applyStimulus(pickOpcode(), 3'($urandom_range(0, 7)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
